// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU sequencer slice.
//   state_e      - sequencer FSM state encoding (3 bits, visible on debug port)
//   PCS_*        - next-PC select encodings driven by the Control decoder
//   DEF_*        - default reset PC and interrupt vector
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_INT   = 3'd4
  } state_e;

  localparam logic [1:0] PCS_INC = 2'd0;  // pc + 1
  localparam logic [1:0] PCS_REL = 2'd1;  // pc + 1 + sext(imm22)
  localparam logic [1:0] PCS_ABS = 2'd2;  // jump_target
  localparam logic [1:0] PCS_BRZ = 2'd3;  // relative if Z, else pc + 1

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC mux/adder.
//   i_pc          current PC
//   i_imm         ir[21:0], signed word offset relative to pc+1
//   i_jump_target absolute target
//   i_zero_flag   ALU Z flag, selects taken/not-taken for PCS_BRZ
//   i_pc_selector PCS_* encoding
//   o_next_pc     selected next PC (mod 2^32, wrap is silent)
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [21:0] i_imm,
  input  logic [31:0] i_jump_target,
  input  logic        i_zero_flag,
  input  logic [1:0]  i_pc_selector,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_inc;
  logic [31:0] w_pc_rel;

  assign w_pc_inc = i_pc + 32'd1;
  assign w_pc_rel = w_pc_inc + {{10{i_imm[21]}}, i_imm};

  always_comb begin
    o_next_pc = w_pc_inc;
    case (i_pc_selector)
      PCS_INC: o_next_pc = w_pc_inc;
      PCS_REL: o_next_pc = w_pc_rel;
      PCS_ABS: o_next_pc = i_jump_target;
      PCS_BRZ: o_next_pc = i_zero_flag ? w_pc_rel : w_pc_inc;
      default: o_next_pc = w_pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer. Owns PC, IR, interrupt
// enable and EPC; steps FETCH -> EXEC -> (MEM) -> (INT) and gates all
// architectural writes through the single-cycle `commit` strobe.
//   clk, rst              clock / async active-low reset
//   instr_ready, ir_in    instruction port handshake and data
//   pc_selector, jump_target, zero_flag, data_access, ion, iof
//                         Control inputs, only looked at in EXEC/MEM
//   data_ready            data memory access complete
//   irq                   level interrupt request, sampled at commit
//   pc, ir, epc, int_enable  architectural state (registered)
//   fetch_req, commit, int_ack  combinational strobes
//   state                 FSM state for debug
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_ready,
  input  logic [31:0] ir_in,
  input  logic [1:0]  pc_selector,
  input  logic [31:0] jump_target,
  input  logic        zero_flag,
  input  logic        data_access,
  input  logic        data_ready,
  input  logic        ion,
  input  logic        iof,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        fetch_req,
  output logic        commit,
  output logic        int_enable,
  output logic        int_ack,
  output logic [31:0] epc,
  output logic [2:0]  state
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_epc;
  logic        r_int_en;
  logic [31:0] w_next_pc;
  logic        w_take_int;

  next_pc_calc u_next_pc (
    .i_pc          (r_pc),
    .i_imm         (r_ir[21:0]),
    .i_jump_target (jump_target),
    .i_zero_flag   (zero_flag),
    .i_pc_selector (pc_selector),
    .o_next_pc     (w_next_pc)
  );

  // Pre-commit enable is used so an ION instruction cannot be interrupted
  // on its own commit (one-instruction shadow).
  assign w_take_int = irq & r_int_en;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = instr_ready ? ST_EXEC : ST_FETCH;
      ST_EXEC: begin
        if (data_access)     w_state_nxt = ST_MEM;
        else if (w_take_int) w_state_nxt = ST_INT;
        else                 w_state_nxt = ST_FETCH;
      end
      ST_MEM: begin
        if (!data_ready)     w_state_nxt = ST_MEM;
        else if (w_take_int) w_state_nxt = ST_INT;
        else                 w_state_nxt = ST_FETCH;
      end
      ST_INT:   w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output strobes
  always_comb begin
    fetch_req = 1'b0;
    commit    = 1'b0;
    int_ack   = 1'b0;
    case (r_state)
      ST_FETCH: fetch_req = 1'b1;
      ST_EXEC:  commit    = ~data_access;
      ST_MEM:   commit    = data_ready;
      ST_INT:   int_ack   = 1'b1;
      default:  ;
    endcase
  end

  // Architectural state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_epc    <= '0;
      r_int_en <= 1'b0;
    end else begin
      if (r_state == ST_FETCH && instr_ready) r_ir <= ir_in;
      if (commit) begin
        r_pc <= w_next_pc;
        // iof has priority over ion
        if (iof)      r_int_en <= 1'b0;
        else if (ion) r_int_en <= 1'b1;
      end
      if (r_state == ST_INT) begin
        r_epc    <= r_pc;
        r_pc     <= INT_VECTOR;
        r_int_en <= 1'b0;
      end
    end
  end

  assign pc         = r_pc;
  assign ir         = r_ir;
  assign epc        = r_epc;
  assign int_enable = r_int_en;
  assign state      = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Inputs change on the falling edge; outputs are checked 1 time unit later,
// well away from the rising edge.
module tb_pc_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_INT   = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_ready = 1'b0;
  logic [31:0] ir_in = '0;
  logic [1:0]  pc_selector = '0;
  logic [31:0] jump_target = '0;
  logic        zero_flag = 1'b0;
  logic        data_access = 1'b0;
  logic        data_ready = 1'b0;
  logic        ion = 1'b0;
  logic        iof = 1'b0;
  logic        irq = 1'b0;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        fetch_req;
  logic        commit;
  logic        int_enable;
  logic        int_ack;
  logic [31:0] epc;
  logic [2:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_ready (instr_ready),
    .ir_in       (ir_in),
    .pc_selector (pc_selector),
    .jump_target (jump_target),
    .zero_flag   (zero_flag),
    .data_access (data_access),
    .data_ready  (data_ready),
    .ion         (ion),
    .iof         (iof),
    .irq         (irq),
    .pc          (pc),
    .ir          (ir),
    .fetch_req   (fetch_req),
    .commit      (commit),
    .int_enable  (int_enable),
    .int_ack     (int_ack),
    .epc         (epc),
    .state       (state)
  );

  // Called at a falling edge while in FETCH; returns at the next falling
  // edge (now in EXEC) with the instruction port idle again.
  task automatic fetch_instr(input logic [31:0] w);
    instr_ready = 1'b1;
    ir_in       = w;
    @(negedge clk);
    instr_ready = 1'b0;
    ir_in       = '0;
  endtask

  task automatic set_ctl(input logic [1:0] sel, input logic [31:0] jt,
                         input logic z, input logic da, input logic on,
                         input logic off, input logic rq);
    pc_selector = sel;
    jump_target = jt;
    zero_flag   = z;
    data_access = da;
    ion         = on;
    iof         = off;
    irq         = rq;
  endtask

  task automatic clr_ctl();
    set_ctl(2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    data_ready = 1'b0;
  endtask

  // Single non-memory instruction, no checks; used only to set up state.
  task automatic run_simple(input logic [31:0] w, input logic [1:0] sel,
                            input logic [31:0] jt, input logic on,
                            input logic off);
    fetch_instr(w);
    set_ctl(sel, jt, 1'b0, 1'b0, on, off, 1'b0);
    @(negedge clk);
    clr_ctl();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state, S_IDLE); end
    n_chk++; if (pc !== 32'd0) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, 32'd0); end
    n_chk++; if (ir !== 32'd0 || epc !== 32'd0) begin n_fail++; $display("FAIL rst_ir_epc: got %h/%h want 0/0", ir, epc); end
    n_chk++; if ({fetch_req, commit, int_ack, int_enable} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {fetch_req, commit, int_ack, int_enable}); end
    @(negedge clk);
    rst = 1'b1;
    instr_ready = 1'b1;
    ir_in = 32'hA5A5_0001;
    #1;
    n_chk++; if (state !== S_IDLE || fetch_req !== 1'b0) begin n_fail++; $display("FAIL idle_after_release: got st=%0d fr=%b want 0/0", state, fetch_req); end
    @(negedge clk); #1;
    n_chk++; if (state !== S_FETCH || fetch_req !== 1'b1) begin n_fail++; $display("FAIL first_fetch: got st=%0d fr=%b want 1/1", state, fetch_req); end
    @(negedge clk);
    instr_ready = 1'b0;
    ir_in = '0;
    #1;
    n_chk++; if (state !== S_EXEC) begin n_fail++; $display("FAIL exec_entry: got %0d want %0d", state, S_EXEC); end
    n_chk++; if (ir !== 32'hA5A5_0001) begin n_fail++; $display("FAIL ir_latch: got %h want %h", ir, 32'hA5A5_0001); end
    set_ctl(2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_chk++; if (commit !== 1'b1) begin n_fail++; $display("FAIL exec_commit: got %b want 1", commit); end
    @(negedge clk);
    clr_ctl();
    #1;
    n_chk++; if (pc !== 32'd1 || state !== S_FETCH) begin n_fail++; $display("FAIL inc_pc: got pc=%h st=%0d want 1/1", pc, state); end
  endtask

  task automatic test_seq_branch();
    // jump to 5, then relative -2: 5 + 1 - 2 = 4
    run_simple(32'd0, 2'd2, 32'd5, 1'b0, 1'b0);
    #1;
    n_chk++; if (pc !== 32'd5) begin n_fail++; $display("FAIL abs_jump: got %h want %h", pc, 32'd5); end
    @(negedge clk);
    run_simple(32'h003F_FFFE, 2'd1, 32'd0, 1'b0, 1'b0);
    #1;
    n_chk++; if (pc !== 32'd4) begin n_fail++; $display("FAIL rel_neg: got %h want %h", pc, 32'd4); end
    // back to 5, BRZ not taken -> 6
    @(negedge clk);
    run_simple(32'd0, 2'd2, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    fetch_instr(32'h0000_0007);
    set_ctl(2'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr_ctl();
    #1;
    n_chk++; if (pc !== 32'd6) begin n_fail++; $display("FAIL brz_not_taken: got %h want %h", pc, 32'd6); end
    // BRZ taken with +3: 6 + 1 + 3 = 10
    @(negedge clk);
    fetch_instr(32'hFFC0_0003);
    set_ctl(2'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr_ctl();
    #1;
    n_chk++; if (pc !== 32'd10) begin n_fail++; $display("FAIL brz_taken: got %h want %h", pc, 32'd10); end
    @(negedge clk);
  endtask

  task automatic test_data_stall();
    int n_commit;
    n_commit = 0;
    fetch_instr(32'd0);
    set_ctl(2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_chk++; if (commit !== 1'b0) begin n_fail++; $display("FAIL exec_mem_commit: got %b want 0", commit); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (commit === 1'b1) n_commit++;
      n_chk++; if (state !== S_MEM || pc !== 32'd10) begin n_fail++; $display("FAIL mem_stall: got st=%0d pc=%h want 3/a", state, pc); end
      @(negedge clk);
    end
    n_chk++; if (n_commit !== 0) begin n_fail++; $display("FAIL stall_commit: got %0d pulses want 0", n_commit); end
    data_ready = 1'b1;
    #1;
    n_chk++; if (commit !== 1'b1) begin n_fail++; $display("FAIL mem_commit: got %b want 1", commit); end
    @(negedge clk);
    clr_ctl();
    #1;
    n_chk++; if (pc !== 32'd11 || state !== S_FETCH || commit !== 1'b0) begin n_fail++; $display("FAIL mem_done: got pc=%h st=%0d c=%b want b/1/0", pc, state, commit); end
  endtask

  task automatic test_interrupt();
    @(negedge clk);
    run_simple(32'd0, 2'd2, 32'd7, 1'b1, 1'b0);
    #1;
    n_chk++; if (int_enable !== 1'b1 || pc !== 32'd7) begin n_fail++; $display("FAIL ion_set: got ie=%b pc=%h want 1/7", int_enable, pc); end
    @(negedge clk);
    fetch_instr(32'd0);
    set_ctl(2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clr_ctl();
    #1;
    n_chk++; if (state !== S_INT || int_ack !== 1'b1) begin n_fail++; $display("FAIL int_entry: got st=%0d ack=%b want 4/1", state, int_ack); end
    n_chk++; if (pc !== 32'd8) begin n_fail++; $display("FAIL int_pc_pre: got %h want %h", pc, 32'd8); end
    @(negedge clk); #1;
    n_chk++; if (state !== S_FETCH || int_ack !== 1'b0) begin n_fail++; $display("FAIL int_exit: got st=%0d ack=%b want 1/0", state, int_ack); end
    n_chk++; if (epc !== 32'd8 || pc !== 32'h100 || int_enable !== 1'b0) begin n_fail++; $display("FAIL int_regs: got epc=%h pc=%h ie=%b want 8/100/0", epc, pc, int_enable); end
  endtask

  task automatic test_ion_shadow();
    // ION with irq at the same commit: no entry, enable becomes 1
    @(negedge clk);
    fetch_instr(32'd0);
    set_ctl(2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    clr_ctl();
    #1;
    n_chk++; if (state !== S_FETCH || int_enable !== 1'b1 || pc !== 32'h101) begin n_fail++; $display("FAIL ion_shadow: got st=%0d ie=%b pc=%h want 1/1/101", state, int_enable, pc); end
    @(negedge clk);
    fetch_instr(32'd0);
    set_ctl(2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clr_ctl();
    #1;
    n_chk++; if (state !== S_INT) begin n_fail++; $display("FAIL int_after_shadow: got %0d want %0d", state, S_INT); end
    @(negedge clk); #1;
    n_chk++; if (epc !== 32'h102 || pc !== 32'h100) begin n_fail++; $display("FAIL shadow_epc: got epc=%h pc=%h want 102/100", epc, pc); end
    // set enable, then ION+IOF together: IOF wins
    @(negedge clk);
    run_simple(32'd0, 2'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    run_simple(32'd0, 2'd0, 32'd0, 1'b1, 1'b1);
    #1;
    n_chk++; if (int_enable !== 1'b0 || pc !== 32'h102) begin n_fail++; $display("FAIL iof_priority: got ie=%b pc=%h want 0/102", int_enable, pc); end
  endtask

  task automatic test_reset_mid();
    int n_commit;
    n_commit = 0;
    @(negedge clk);
    fetch_instr(32'd0);
    set_ctl(2'd2, 32'h0000_0ABC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    n_chk++; if (state !== S_MEM) begin n_fail++; $display("FAIL mem_before_rst: got %0d want %0d", state, S_MEM); end
    rst = 1'b0;
    data_ready = 1'b1;
    #1;
    if (commit === 1'b1) n_commit++;
    n_chk++; if (state !== S_IDLE || pc !== 32'd0) begin n_fail++; $display("FAIL rst_abort: got st=%0d pc=%h want 0/0", state, pc); end
    @(negedge clk); #1;
    if (commit === 1'b1) n_commit++;
    n_chk++; if (pc !== 32'd0 || n_commit !== 0) begin n_fail++; $display("FAIL rst_no_commit: got pc=%h pulses=%0d want 0/0", pc, n_commit); end
    rst = 1'b1;
    clr_ctl();
    @(negedge clk); #1;
    n_chk++; if (state !== S_FETCH) begin n_fail++; $display("FAIL rst_refetch: got %0d want %0d", state, S_FETCH); end
  endtask

  task automatic test_wrap();
    run_simple(32'd0, 2'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #1;
    n_chk++; if (pc !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_setup: got %h want ffffffff", pc); end
    @(negedge clk);
    run_simple(32'd0, 2'd0, 32'd0, 1'b0, 1'b0);
    #1;
    n_chk++; if (pc !== 32'd0) begin n_fail++; $display("FAIL wrap_inc: got %h want 0", pc); end
    // relative wrap backwards: 0 + 1 - 2 = FFFFFFFF
    @(negedge clk);
    run_simple(32'h003F_FFFE, 2'd1, 32'd0, 1'b0, 1'b0);
    #1;
    n_chk++; if (pc !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_rel: got %h want ffffffff", pc); end
  endtask

  initial begin
    test_reset();
    test_seq_branch();
    test_data_stall();
    test_interrupt();
    test_ion_shadow();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer for the 32-bit CPU. It owns the program counter, instruction register, interrupt-enable flag and saved-PC (EPC). It steps each instruction through fetch, execute, optional data-memory access and interrupt entry. It sits between the Memory instruction port and the combinational Control decoder, and gates all architectural writes through a single `commit` strobe.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `INT_VECTOR`, 32'h0000_0100, PC loaded on interrupt entry

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-low
- `instr_ready`  in  1  memory presents a valid instruction on `ir_in`
- `ir_in`  in  32  instruction word from memory
- `pc_selector`  in  2  next-PC select from Control: 0 = PC+1, 1 = relative, 2 = absolute `jump_target`, 3 = relative if `zero_flag` else PC+1
- `jump_target`  in  32  absolute target (register data 1)
- `zero_flag`  in  1  ALU Z flag for the current instruction
- `data_access`  in  1  current instruction uses the data memory port
- `data_ready`  in  1  data memory access complete
- `ion`, `iof`  in  1  Control requests interrupt enable or disable
- `irq`  in  1  level-sensitive interrupt request
- `pc`  out  32  current program counter
- `ir`  out  32  latched instruction
- `fetch_req`  out  1  instruction read request
- `commit`  out  1  one-cycle strobe enabling register-file and memory writes
- `int_enable`  out  1  interrupt-enable flag (INT bit of the flag register)
- `int_ack`  out  1  one-cycle interrupt acknowledge
- `epc`  out  32  PC saved at interrupt entry
- `state`  out  3  FSM state, for debug

## Operation
- States: IDLE=0, FETCH=1, EXEC=2, MEM=3, INT=4.
- IDLE: entered on reset. Leaves for FETCH on the first clock after `rst` deasserts.
- FETCH: `fetch_req`=1.
  - While `instr_ready`=0: stay in FETCH.
  - On `instr_ready`=1: `ir` <= `ir_in`, go to EXEC.
- EXEC:
  - If `data_access`=1: go to MEM, no commit.
  - Otherwise: commit this cycle.
- MEM: wait for `data_ready`. Commit in the cycle where `data_ready`=1.
- A commit cycle performs all of the following together:
  - `commit`=1.
  - `pc` <= next_pc.
  - `int_enable` update: `iof` clears it, `ion` sets it; if both are 1, `iof` wins.
  - Next state is INT if `irq`=1 and the pre-commit `int_enable`=1, else FETCH. Using the pre-commit value gives an ION instruction a one-instruction shadow.
- next_pc:
  - rel = pc + 1 + sign-extend(`ir`[21:0]) to 32 bits.
  - abs = `jump_target`.
  - All arithmetic is mod 2^32; wrap from 32'hFFFF_FFFF to 0 is silent.
- INT (one cycle):
  - `epc` <= `pc` (already the next instruction).
  - `pc` <= `INT_VECTOR`.
  - `int_enable` <= 0.
  - `int_ack`=1.
  - Go to FETCH.
- `irq` is sampled only at commit, never mid-instruction.
- Reset values: `pc`=`RESET_PC`, `ir`=0, `epc`=0, `int_enable`=0, state=IDLE. All strobes (`fetch_req`, `commit`, `int_ack`) are 0.
- Reset asserted in any state aborts the instruction immediately. No commit occurs and no PC update survives.

## Timing
- `fetch_req`, `commit`, `int_ack`: decoded combinationally from state and current inputs. No registered delay.
- `pc`, `ir`, `epc`, `int_enable`: registered, updated on the rising edge ending the relevant cycle.
- Minimum instruction latency, counted from FETCH entry to the next FETCH entry:
  - 2 cycles without data access (`instr_ready` already high).
  - 3 cycles with data access (`data_ready` high on first MEM cycle).
  - +1 cycle when an interrupt is taken.
- `instr_ready` and `data_ready` may stall indefinitely. All outputs hold during a stall.
- Control inputs (`pc_selector`, `jump_target`, `zero_flag`, `ion`, `iof`, `data_access`) are valid only in EXEC and MEM. They are ignored in all other states.

## Structure
- Shared package `cpu_pkg`:
  - state enum (IDLE/FETCH/EXEC/MEM/INT, 3 bits).
  - `pc_selector` encodings (PCS_INC, PCS_REL, PCS_ABS, PCS_BRZ).
  - Default `RESET_PC` / `INT_VECTOR` constants.
- One sub-module, `next_pc_calc`: combinational next_pc mux and adder from `pc`, `ir`[21:0], `jump_target`, `zero_flag`, `pc_selector`.

## Test plan
- Reset then fetch:
  - Stimulus: `rst`=0 for 3 cycles, release, `instr_ready`=1.
  - Response: `pc`=0 and `fetch_req`=0 in IDLE; `fetch_req`=1 on the next cycle; `ir` latched one cycle later.
- Sequential and branch:
  - Stimulus: `pc`=5, `ir`[21:0]=22'h3FFFFE (-2), `pc_selector`=1.
  - Response: `pc`=4 after commit.
  - Stimulus: `pc_selector`=3 with `zero_flag`=0.
  - Response: `pc`=6.
- Data stall:
  - Stimulus: `data_access`=1, `data_ready` low for 4 cycles.
  - Response: `commit` stays 0 for those cycles, then pulses once in the `data_ready` cycle; `pc` increments by exactly 1.
- Interrupt entry:
  - Stimulus: `int_enable`=1, `irq`=1 at the commit of the instruction at `pc`=7.
  - Response: INT state for one cycle, `epc`=8, `pc`=32'h100, `int_acknowledge`... specifically `int_ack` high for one cycle, `int_enable`=0.
- ION shadow and priority:
  - Stimulus: `ion`=1 with `irq`=1 at the same commit.
  - Response: no INT entry; INT entry at the next commit.
  - Stimulus: `ion`=`iof`=1.
  - Response: `int_enable`=0.
- Reset mid-instruction and wrap:
  - Stimulus: assert `rst` in MEM.
  - Response: state=IDLE, `pc`=`RESET_PC`, no `commit` pulse.
  - Stimulus: `pc`=32'hFFFF_FFFF with `pc_selector`=0.
  - Response: `pc`=0.
